// File: rtl/keypad_scan_if.sv
// keypad_scan_if: key handshake between the keypad scanner and the code-input stage.
// keyValue is settled before keySured rises; keySured is a level held while a key is accepted.
interface keypad_scan_if;
  logic [3:0] keyValue;
  logic       keySured;

  modport master (output keyValue, output keySured);
  modport slave  (input  keyValue, input  keySured);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with press/release debounce and key encode.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of keySured while a key is held.
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned REPEAT_CYC   = 25000000
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [3:0]    row,
  output logic [3:0]    col,
  keypad_scan_if.master key
);

  typedef enum logic [2:0] {
    StScan, StDebounce, StLatch, StPressed, StRelease, StGap
  } state_e;

  localparam logic [23:0] SCAN_LAST = 24'(SCAN_DIV - 1);
  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYC - 1);
  // The PRESSED cycle that first sees all-high counts as the first release cycle.
  localparam logic [23:0] REL_LAST  = (DEBOUNCE_CYC > 1) ? 24'(DEBOUNCE_CYC - 2) : 24'd0;

  state_e      state_q;
  logic [23:0] cnt_q;
  logic [1:0]  col_idx_q;
  logic [3:0]  row_s1_q, rs_q, row_held_q;
  logic [3:0]  key_value_q;
  logic        key_sured_q;
  logic        hit, all_high;

  function automatic logic [3:0] encode(input logic [3:0] rows, input logic [1:0] c);
    logic [1:0] r;
    case (rows)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    case ({r, c})
      4'h0: encode = 4'h1;  4'h1: encode = 4'h2;  4'h2: encode = 4'h3;  4'h3: encode = 4'hA;
      4'h4: encode = 4'h4;  4'h5: encode = 4'h5;  4'h6: encode = 4'h6;  4'h7: encode = 4'hB;
      4'h8: encode = 4'h7;  4'h9: encode = 4'h8;  4'hA: encode = 4'h9;  4'hB: encode = 4'hC;
      4'hC: encode = 4'hE;  4'hD: encode = 4'h0;  4'hE: encode = 4'hF;  default: encode = 4'hD;
    endcase
  endfunction

  assign hit      = $onehot(~rs_q);
  assign all_high = &rs_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_s1_q    <= 4'hF;
      rs_q        <= 4'hF;
      row_held_q  <= 4'hF;
      state_q     <= StScan;
      cnt_q       <= '0;
      col_idx_q   <= '0;
      key_value_q <= '0;
      key_sured_q <= 1'b0;
    end else begin
      row_s1_q <= row;
      rs_q     <= row_s1_q;
      case (state_q)
        StScan: begin
          if (hit) begin
            row_held_q <= rs_q;
            state_q    <= StDebounce;
            cnt_q      <= '0;
          end else if (cnt_q == SCAN_LAST) begin
            cnt_q     <= '0;
            col_idx_q <= col_idx_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StDebounce: begin
          if (rs_q != row_held_q) begin
            state_q <= StScan;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            key_value_q <= encode(row_held_q, col_idx_q);
            state_q     <= StLatch;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StLatch: begin
          key_sured_q <= 1'b1;
          state_q     <= StPressed;
          cnt_q       <= '0;
        end
        StPressed: begin
          // Any pattern other than all-high (second key, other row) keeps the key held.
          if (all_high) begin
            state_q <= StRelease;
            cnt_q   <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (cnt_q == 24'(REPEAT_CYC - 1)) begin
            key_sured_q <= 1'b0;
            state_q     <= StGap;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
`endif
        end
        StRelease: begin
          if (!all_high) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_q == REL_LAST) begin
            key_sured_q <= 1'b0;
            state_q     <= StScan;
            cnt_q       <= '0;
            col_idx_q   <= col_idx_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
`ifdef KEYPAD_REPEAT_EN
        StGap: begin
          if (all_high) begin
            state_q <= StRelease;
            cnt_q   <= '0;
          end else if (cnt_q == 24'd3) begin
            key_sured_q <= 1'b1;
            state_q     <= StPressed;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
`endif
        default: begin
          state_q <= StScan;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifndef KEYPAD_REPEAT_EN
  logic unused_repeat_cyc;
  assign unused_repeat_cyc = ^REPEAT_CYC;
`endif

  assign col          = ~(4'b0001 << col_idx_q);
  assign key.keyValue = key_value_q;
  assign key.keySured = key_sured_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed and randomized key presses against a key-map / latency reference model.
`timescale 1ns/1ps
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DC = 8;
  localparam int RC = 64;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [3:0]  row, col;
  logic [15:0] pressed = '0;  // bit r*4+c set while key (r,c) is held down
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Key map by r*4+c, row-major.
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC), .REPEAT_CYC(RC)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .row   (row),
    .col   (col),
    .key   (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  logic       ks_prev = 1'b0;
  logic [3:0] kv_prev = 4'h0;
  int         rise_cyc[$];
  logic [3:0] rise_val[$];
  int         fall_cyc[$];
  int         kv_cyc[$];

  always @(negedge clk) begin
    if (kif.keySured === 1'b1 && ks_prev === 1'b0) begin
      rise_cyc.push_back(cyc);
      rise_val.push_back(kif.keyValue);
    end
    if (kif.keySured === 1'b0 && ks_prev === 1'b1) fall_cyc.push_back(cyc);
    if (kif.keyValue !== kv_prev) kv_cyc.push_back(cyc);
    ks_prev = kif.keySured;
    kv_prev = kif.keyValue;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ks(input logic lvl, input int bound, input string tag);
    int n = 0;
    while (kif.keySured !== lvl && n < bound) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, kif.keySured}, {31'd0, lvl});
  endtask

  // Returns right after the edge on which column c becomes driven.
  task automatic wait_col_start(input int c);
    int n = 0;
    while (col[c] !== 1'b1 && n < 64) begin step(1); n++; end
    while (col[c] !== 1'b0 && n < 64) begin step(1); n++; end
    chk("col_wait", {31'd0, col[c]}, 32'd0);
  endtask

  task automatic press_key(input int r, input int c, input int hold, input bit bounce);
    logic [3:0] v;
    if (bounce) repeat (3) begin
      pressed[r*4+c] = 1'b1; step(2);
      pressed[r*4+c] = 1'b0; step(1);
    end
    pressed[r*4+c] = 1'b1;
    wait_ks(1'b1, 4*SD + DC + 24, "press_rise");
    v = kif.keyValue;
    chk("press_value", v, kmap[r*4+c]);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("value_stable", kif.keyValue, v);
    end
    step(hold);
    if (bounce) repeat (3) begin
      pressed[r*4+c] = 1'b0; step(2);
      pressed[r*4+c] = 1'b1; step(1);
    end
    pressed[r*4+c] = 1'b0;
    wait_ks(1'b0, DC + 12, "release_fall");
    step(2);
  endtask

  function automatic int find_key(input logic [3:0] v);
    for (int i = 0; i < 16; i++) if (kmap[i] == v) return i;
    return 0;
  endfunction

  initial begin
    logic [3:0]  exp_col;
    logic [3:0]  prev_col;
    logic [3:0]  exp_q[$];
    int          p, rel, n0, f0, lat, changes, k;

    // Reset and idle scanning
    #2 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    #1;
    chk("reset_col", col, 4'b1110);
    chk("reset_value", kif.keyValue, 4'h0);
    chk("reset_sured", {31'd0, kif.keySured}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      exp_col = 4'b1111;
      exp_col[(i / 4) % 4] = 1'b0;
      chk("idle_col", col, exp_col);
    end

    // Clean press r0/c1: exact press and release latency
    wait_col_start(1);
    p = cyc;
    pressed[1] = 1'b1;
    wait_ks(1'b1, 40, "clean_rise");
    chk("clean_rise_lat", cyc - p, 3 + DC + 1);
    lat = (kv_cyc.size() > 0) ? kv_cyc[$] - p : -1;
    chk("clean_value_lat", lat, 3 + DC);
    chk("clean_value", kif.keyValue, 4'h2);
    while (cyc < p + 40) step(1);
    rel = cyc;
    pressed[1] = 1'b0;
    wait_ks(1'b0, 40, "clean_fall");
    chk("clean_fall_lat", cyc - rel, 2 + DC);
    chk("clean_resume_col", col, 4'b1011);

    // Bouncing press and release of r3/c1: one pulse, value 0
    wait_col_start(1);
    n0 = rise_cyc.size();
    press_key(3, 1, 30, 1'b1);
    step(20);
    chk("bounce_pulses", rise_cyc.size() - n0, 1);
    chk("bounce_value", (rise_cyc.size() > n0) ? rise_val[n0] : 4'hX, 4'h0);

    // Two rows low on c0 is no hit; dropping one leaves key 4
    n0 = rise_cyc.size();
    pressed[4] = 1'b1;
    pressed[8] = 1'b1;
    prev_col = col;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (col != prev_col) changes++;
      prev_col = col;
    end
    chk("dual_no_pulse", rise_cyc.size() - n0, 0);
    chk("dual_scanning", {31'd0, changes >= 8}, 32'd1);
    pressed[8] = 1'b0;
    wait_ks(1'b1, 4*SD + DC + 24, "dual_rise");
    chk("dual_value", kif.keyValue, 4'h4);
    pressed[4] = 1'b0;
    wait_ks(1'b0, DC + 12, "dual_fall");
    step(2);

    // Sequential entry of 0..5
    n0 = rise_cyc.size();
    for (int v = 0; v < 6; v++) begin
      k = find_key(4'(v));
      press_key(k / 4, k % 4, 6, 1'b0);
    end
    chk("seq_pulses", rise_cyc.size() - n0, 6);
    for (int v = 0; v < 6; v++)
      if (n0 + v < rise_cyc.size()) chk("seq_order", rise_val[n0 + v], 4'(v));

    // Randomized presses against the key map
    n0 = rise_cyc.size();
    exp_q = {};
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 15);
      exp_q.push_back(kmap[k]);
      press_key(k / 4, k % 4, $urandom_range(2, 36), 1'($urandom_range(0, 1)));
    end
    chk("rand_pulses", rise_cyc.size() - n0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (n0 + i < rise_cyc.size()) chk("rand_order", rise_val[n0 + i], exp_q[i]);

    // Asynchronous reset while a key is held
    pressed[5] = 1'b1;
    wait_ks(1'b1, 4*SD + DC + 24, "rst_rise");
    step(3);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_sured", {31'd0, kif.keySured}, 32'd0);
    chk("rst_col", col, 4'b1110);
    chk("rst_value", kif.keyValue, 4'h0);
    pressed[5] = 1'b0;
    step(3);
    chk("rst_held_sured", {31'd0, kif.keySured}, 32'd0);
    n0 = rise_cyc.size();
    @(negedge clk) n_rst = 1'b1;
    step(40);
    chk("rst_no_pulse", rise_cyc.size() - n0, 0);

`ifdef KEYPAD_REPEAT_EN
    // Held key 9 for 200 cycles: initial edge plus two repeats, each after 4 low cycles
    n0 = rise_cyc.size();
    f0 = fall_cyc.size();
    pressed[10] = 1'b1;
    step(200);
    pressed[10] = 1'b0;
    wait_ks(1'b0, DC + 12, "rep_fall");
    step(4);
    chk("rep_pulses", rise_cyc.size() - n0, 3);
    for (int i = 1; i < 3; i++)
      if (n0 + i < rise_cyc.size() && f0 + i - 1 < fall_cyc.size())
        chk("rep_low_gap", rise_cyc[n0 + i] - fall_cyc[f0 + i - 1], 4);
    for (int i = 0; i < 3; i++)
      if (n0 + i < rise_cyc.size()) chk("rep_value", rise_val[n0 + i], 4'h9);
`else
    f0 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Upstream front end for the code-lock password path. Scans a 4×4 active-low matrix keypad, debounces press and release, and encodes the key. It presents the key to the code-input stage as a stable `keyValue` plus a level `keySured` that rises once per accepted press. `keyValue` is valid before `keySured` rises, so the consumer's rising-edge detection and few-cycle settle wait always sample a stable value.

## Interface
- `SCAN_DIV`, 1000: clk cycles each column is driven while scanning (≥2).
- `DEBOUNCE_CYC`, 20000: consecutive stable cycles needed to accept a press or a release (≥1).
- `REPEAT_CYC`, 25000000: hold time between auto-repeats (used only with `KEYPAD_REPEAT_EN`).
- `clk` input 1: system clock.
- `n_rst` input 1: asynchronous, active-low reset.
- `row` input 4: keypad rows, active-low, externally pulled up, asynchronous.
- `col` output 4: column drive, one-hot active-low.
- `keyValue` output 4: encoded key; holds the last accepted key.
- `keySured` output 1: high while an accepted key is held.

## Operation
- Row sync: `row` passes through a 2-flop synchronizer; `rs` denotes the synced value.
- Hit on the active column: `rs` has exactly one bit low. All-high or ≥2 low is no hit.
- Column index c: bit c of `col` is low. `col` is 1110 for c=0, rotating left.
- Key map, row r / column c:
  - r0 = 1, 2, 3, A
  - r1 = 4, 5, 6, B
  - r2 = 7, 8, 9, C
  - r3 = E(*), 0, F(#), D
- State machine; a 24-bit counter is shared by all states and cleared on every state change.
  - SCAN:
    - Drives column c; counter counts to `SCAN_DIV`-1.
    - On a hit: capture `rs` into `rowHeld` and go to DEBOUNCE, with the column frozen.
    - Otherwise at terminal count: c ← c+1 mod 4.
  - DEBOUNCE:
    - If `rs` ≠ `rowHeld`: return to SCAN with the same column and the counter cleared.
    - After `DEBOUNCE_CYC` stable cycles: write `keyValue` and go to LATCH.
  - LATCH: 1 cycle, then `keySured` ← 1 and go to PRESSED.
  - PRESSED:
    - Column stays frozen.
    - If `rs` is all-high: go to RELEASE.
    - Other row changes, including a second key or a different row, are ignored.
  - RELEASE:
    - If any `rs` bit goes low: return to PRESSED and clear the counter.
    - After `DEBOUNCE_CYC` all-high cycles: `keySured` ← 0, go to SCAN, c ← c+1 mod 4.
- Exactly one `keySured` rising edge per accepted press; bounces never create extra edges.
- `keyValue` changes only in the DEBOUNCE→LATCH transition.

## Timing
- Reset values: `col`=1110, `keyValue`=0, `keySured`=0, state SCAN, counters 0, synchronizer 1111.
- Reset mid-operation returns everything to these values immediately, with no further `keySured` edges.
- Press latency, from a stable `row` change on the scanned column to the `keyValue` update: 2 sync + 1 hit-detect + `DEBOUNCE_CYC` cycles.
- `keySured` rises exactly 1 cycle after `keyValue` updates.
- Release latency, from all rows high to `keySured` falling: 2 + `DEBOUNCE_CYC` cycles, plus restart cycles on any bounce.
- Worst-case detect delay for a newly pressed key: 4·`SCAN_DIV` cycles.
- Minimum `keySured` low time between presses: 1 full DEBOUNCE + LATCH cycle.

## Configuration
- `KEYPAD_REPEAT_EN` defined: after `REPEAT_CYC` cycles in PRESSED, `keySured` goes low for 4 cycles and then high again, with `keyValue` unchanged. The repeat counter restarts after each repeat, and repeats continue until release. Release during the 4 low cycles goes straight to RELEASE with `keySured` kept low.
- Not defined: `REPEAT_CYC` is unused; one edge per press.

## Test plan
Parameters for all scenarios: `SCAN_DIV`=4, `DEBOUNCE_CYC`=8, `REPEAT_CYC`=64.
- Reset, no keys: `col` cycles 1110→1101→1011→0111, 4 cycles each; `keySured`=0, `keyValue`=0.
- Press r0/c1 clean, hold 40 cycles, release: `keyValue`=2 exactly 1 cycle before `keySured`↑. `keySured`↓ 10 cycles after release. Scanning resumes at 1011.
- Press r3/c1 with 3 bounces (glitches every 3 cycles) on press and on release: exactly one `keySured` pulse, `keyValue`=0.
- Rows r1 and r2 low together on c0: no `keySured`, scanning continues. Then release r2: `keyValue`=4, `keySured`↑.
- Enter 0,1,2,3,4,5 sequentially: 6 pulses with values 0..5 in order; each `keyValue` is stable ≥4 cycles after `keySured`↑.
- `n_rst` low during PRESSED: `keySured`=0 and `col`=1110 immediately. With `KEYPAD_REPEAT_EN`, holding key 9 for 200 cycles gives 1 initial edge plus 2 repeat edges, each preceded by 4 low cycles.
